// File: rtl/mem_arbiter.sv
// Three-port SRAM arbiter (loader, load/store, fetch) with a read tag pipeline.
// Define MEMARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.

module mem_arbiter #(
    parameter int unsigned MEM_AW       = 10,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    input  logic              dt_req,
    input  logic              dt_we,
    input  logic [31:0]       dt_addr,
    input  logic [31:0]       dt_wdata,
    output logic              dt_gnt,
    output logic              dt_rvalid,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        starved
);

    localparam logic [1:0] ID_LD = 2'd0;
    localparam logic [1:0] ID_DT = 2'd1;
    localparam logic [1:0] ID_IF = 2'd2;

    logic       w_gnt_vld;
    logic       w_gnt_act;
    logic [1:0] w_gnt_id;

`ifdef MEMARB_ROUND_ROBIN_EN
    logic [1:0] r_ptr;

    // Search order starts just after the last granted port.
    always_comb begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ID_LD;
        unique case (r_ptr)
            ID_LD: begin
                if (dt_req)      w_gnt_id = ID_DT;
                else if (if_req) w_gnt_id = ID_IF;
                else if (ld_req) w_gnt_id = ID_LD;
                else             w_gnt_vld = 1'b0;
            end
            ID_DT: begin
                if (if_req)      w_gnt_id = ID_IF;
                else if (ld_req) w_gnt_id = ID_LD;
                else if (dt_req) w_gnt_id = ID_DT;
                else             w_gnt_vld = 1'b0;
            end
            default: begin
                if (ld_req)      w_gnt_id = ID_LD;
                else if (dt_req) w_gnt_id = ID_DT;
                else if (if_req) w_gnt_id = ID_IF;
                else             w_gnt_vld = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= ID_IF;
        end else if (w_gnt_vld) begin
            r_ptr <= w_gnt_id;
        end
    end

    assign starved = 3'b000;
`else
    localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_dt_cnt;
    logic [CNT_W-1:0] r_if_cnt;
    logic             w_dt_stv;
    logic             w_if_stv;

    assign w_dt_stv = (r_dt_cnt == CNT_MAX);
    assign w_if_stv = (r_if_cnt == CNT_MAX);

    // A starved requester outranks everything else; dt wins a starvation tie.
    always_comb begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ID_LD;
        if (w_dt_stv && dt_req)      w_gnt_id = ID_DT;
        else if (w_if_stv && if_req) w_gnt_id = ID_IF;
        else if (ld_req)             w_gnt_id = ID_LD;
        else if (dt_req)             w_gnt_id = ID_DT;
        else if (if_req)             w_gnt_id = ID_IF;
        else                         w_gnt_vld = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dt_cnt <= '0;
            r_if_cnt <= '0;
        end else begin
            if (!dt_req || (w_gnt_vld && w_gnt_id == ID_DT)) r_dt_cnt <= '0;
            else if (!w_dt_stv)                              r_dt_cnt <= r_dt_cnt + CNT_W'(1);
            if (!if_req || (w_gnt_vld && w_gnt_id == ID_IF)) r_if_cnt <= '0;
            else if (!w_if_stv)                              r_if_cnt <= r_if_cnt + CNT_W'(1);
        end
    end

    assign starved = reset ? 3'b000 : {w_if_stv, w_dt_stv, 1'b0};
`endif

    assign w_gnt_act = w_gnt_vld && !reset;
    assign ld_gnt    = w_gnt_act && (w_gnt_id == ID_LD);
    assign dt_gnt    = w_gnt_act && (w_gnt_id == ID_DT);
    assign if_gnt    = w_gnt_act && (w_gnt_id == ID_IF);

    always_comb begin
        mem_en    = w_gnt_act;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt_act) begin
            unique case (w_gnt_id)
                ID_LD: begin
                    mem_we    = ld_we;
                    mem_addr  = ld_addr[MEM_AW+1:2];
                    mem_wdata = ld_wdata;
                end
                ID_DT: begin
                    mem_we    = dt_we;
                    mem_addr  = dt_addr[MEM_AW+1:2];
                    mem_wdata = dt_wdata;
                end
                ID_IF: begin
                    mem_addr  = if_addr[MEM_AW+1:2];
                end
                default: begin
                    mem_en    = 1'b0;
                end
            endcase
        end
    end

    logic       r_tag0_vld;
    logic [1:0] r_tag0_id;
    logic       w_last_vld;
    logic [1:0] w_last_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag0_vld <= 1'b0;
            r_tag0_id  <= ID_LD;
        end else begin
            r_tag0_vld <= w_gnt_act && !mem_we;
            r_tag0_id  <= w_gnt_id;
        end
    end

    generate
        if (MEM_LAT >= 2) begin : g_lat2
            logic       r_tag1_vld;
            logic [1:0] r_tag1_id;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_tag1_vld <= 1'b0;
                    r_tag1_id  <= ID_LD;
                end else begin
                    r_tag1_vld <= r_tag0_vld;
                    r_tag1_id  <= r_tag0_id;
                end
            end

            assign w_last_vld = r_tag1_vld;
            assign w_last_id  = r_tag1_id;
        end else begin : g_lat1
            assign w_last_vld = r_tag0_vld;
            assign w_last_id  = r_tag0_id;
        end
    endgenerate

    assign ld_rvalid = !reset && w_last_vld && (w_last_id == ID_LD);
    assign dt_rvalid = !reset && w_last_vld && (w_last_id == ID_DT);
    assign if_rvalid = !reset && w_last_vld && (w_last_id == ID_IF);
    assign rdata     = mem_rdata;

    // Byte-offset and upper address bits are not part of the word address.
    logic w_unused;
    assign w_unused = ^{ld_addr[31:MEM_AW+2], ld_addr[1:0], dt_addr[31:MEM_AW+2], dt_addr[1:0],
                        if_addr[31:MEM_AW+2], if_addr[1:0]};

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Three-port arbiter that shares one single-port, word-addressed SRAM among the program loader, the core's load/store port and the core's instruction-fetch port. It sits between the `riscv` core, the loader, and the unified memory. It issues at most one access per cycle and returns read data after a fixed memory latency. It tracks outstanding reads in a tag pipeline so each read response is steered back to its requester.

## Interface
Parameters:
- `MEM_AW`, 10: SRAM word-address width; `mem_addr` = `addr[MEM_AW+1:2]` of the granted port.
- `MEM_LAT`, 1: SRAM read latency in cycles; legal values are 1 and 2.
- `STARVE_LIMIT`, 8: number of consecutive waiting cycles after which a lower-priority port is force-granted (fixed-priority mode only).

Ports (x = `ld`, `dt`, `if`; port indices 0/1/2):
- `clk`  in  1  clock
- `reset`  in  1  Synchronous, active-high reset; clock is `clk`.
- `x_req`  in  1  access request; held until `x_gnt`.
- `x_we`  in  1  write enable; `if_we` does not exist (the fetch port is read-only).
- `x_addr`  in  32  byte address; bits [1:0] are ignored.
- `x_wdata`  in  32  write data (`ld`, `dt` only).
- `x_gnt`  out  1  one-cycle grant; the request is accepted this cycle.
- `x_rvalid`  out  1  read data valid for this port.
- `rdata`  out  32  shared read-data bus, qualified by `x_rvalid`.
- `mem_en`  out  1  SRAM access strobe.
- `mem_we`  out  1  SRAM write.
- `mem_addr`  out  MEM_AW  SRAM word address.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data, valid MEM_LAT cycles after `mem_en` with `!mem_we`.
- `starved`  out  3  per-port flag, set while that port's starvation counter is at limit.

## Operation
- **Request handling:** Each cycle, the requesting ports are evaluated and at most one `x_gnt` is asserted. The granted port's `we/addr/wdata` drive `mem_*` combinationally, with `mem_en`=1. With no request, `mem_en`=0 and `mem_we`=0.
- **Fixed-priority mode:** Priority is `ld` > `dt` > `if`.
- **Starvation counters:** `dt` and `if` each have a starvation counter, width clog2(STARVE_LIMIT+1).
  - Increments when the port has `req` && !`gnt`.
  - Clears on `gnt` or when `req`=0.
  - Saturates at STARVE_LIMIT.
- **Starvation override:** A port whose counter equals STARVE_LIMIT beats every non-starved port. If both `dt` and `if` are starved, `dt` wins.
- **Read tag pipeline:** MEM_LAT stages, each holding {valid, 2-bit port id}.
  - Stage 0 is loaded with {gnt && !we, id} every cycle.
  - The last stage drives `x_rvalid` for the matching id.
- **Read data:** `rdata` = `mem_rdata` (pass-through). It is don't-care when no `rvalid` is asserted.
- **Writes:** Writes produce no `rvalid`.
- **Ordering:** Responses return in grant order. Back-to-back reads from any mix of ports are allowed, one per cycle.
- **`fetch` ignores `we`:** Any `if` access is a read.

## Timing
- **Reset values:** While `reset` is high, all `x_gnt`, `x_rvalid`, `mem_en`, `mem_we` and `starved` are 0, and `mem_addr`/`mem_wdata` are 0. Tag pipeline valids clear and counters clear.
- **Reset mid-operation:** A read granted before reset never produces `rvalid`. The first grant is possible in the first cycle with `reset`=0.
- **Grant timing:** Grant is same-cycle as request (0-cycle arbitration latency). After grant, the requester may drop `req` or present a new request in the next cycle.
- **Read latency:** A read granted in cycle N gives `x_rvalid`=1 with valid `rdata` in cycle N+MEM_LAT, for exactly one cycle.
- **Simultaneous read response and new grant:** Both are allowed in the same cycle, with no bubble.
- **Read-after-write:** A write granted in cycle N is visible to a read granted in cycle N+1.
- **Counter limit:** A counter reaching STARVE_LIMIT in cycle N forces that port's grant in cycle N+1 if `req` is still high. `starved` is asserted in cycle N+1 and clears the cycle after the grant.

## Configuration
- Macro: `MEMARB_ROUND_ROBIN_EN`.
- **Defined:** Round-robin arbitration.
  - A 2-bit pointer holds the last granted port.
  - The search starts at pointer+1 mod 3.
  - The pointer updates only on a grant and resets to 2, so `ld` is first after reset.
  - Starvation counters are not built; `starved` is tied to 0 and STARVE_LIMIT is unused.
- **Undefined:** Fixed priority with starvation override, as in Operation.

## Test plan
- **Reset mid-read:** Reset for 2 cycles, then `dt` read at 0x40 with SRAM word 0x10 = 0xDEADBEEF, MEM_LAT=1 → `dt_gnt` in cycle 0, `dt_rvalid`/`rdata`=0xDEADBEEF in cycle 1. Assert `reset` in cycle 1 of a second such read → no `dt_rvalid` afterwards.
- **Simultaneous requests (fixed priority):** `ld` write 0x11 to 0x0, `dt` read 0x0 and `if` read 0x4 all asserted in cycle 0 → grants `ld` cycle 0, `dt` cycle 1, `if` cycle 2. `dt_rvalid` in cycle 2 carries 0x11.
- **Starvation (fixed priority):** `dt` requests continuously and `if` requests continuously, STARVE_LIMIT=8 → `if_gnt` no later than cycle 9, with `starved[2]`=1 in that cycle.
- **Latency pipelining:** MEM_LAT=2, alternating `if`/`dt` reads to distinct addresses for 10 cycles → each `rvalid` arrives exactly 2 cycles after its grant, on the correct port, with the correct data, and no gaps.
- **Round-robin (`MEMARB_ROUND_ROBIN_EN`):** All three ports requesting continuously → grant sequence `ld`, `dt`, `if`, `ld`, …, and `starved` stays 0.
- **Fetch write ignored:** Present an `if` request while `ld`/`dt` are idle → `mem_we`=0 always, and a one-cycle `x_gnt` is never repeated without a new `req`.
